frame_base_stack: RTL and testbench

//  Holds the current register-frame base pointer that feeds the srf-relative

---
 rtl/frame_base_stack_if.sv | 27 ++
 rtl/frame_base_stack.sv | 75 +++++++
 tb/tb_frame_base_stack.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/frame_base_stack_if.sv
// Decoder-to-frame-stack link: call/ret requests in, current base and stack status out.
interface frame_base_stack_if #(
    parameter int MDATAW = 8,
    parameter int PTRW   = 3
);
    logic              call;
    logic              ret;
    logic              rel;
    logic [MDATAW-1:0] new_base;
    logic              clr_err;
    logic [MDATAW-1:0] base;
    logic [PTRW:0]     level;
    logic              full;
    logic              empty;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output call, ret, rel, new_base, clr_err,
        input  base, level, full, empty, err_ovf, err_unf
    );

    modport slave (
        input  call, ret, rel, new_base, clr_err,
        output base, level, full, empty, err_ovf, err_unf
    );
endinterface

// File: rtl/frame_base_stack.sv
// Current register-frame base plus a LIFO of saved bases for nested calls.
// CALL pushes the current base and installs a new one; RET restores the saved one.
module frame_base_stack #(
    parameter int MDATAW = 8,
    parameter int DEPTH  = 8,
    parameter int PTRW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    frame_base_stack_if.slave   bus
);
    localparam logic [PTRW:0] LVL_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW:0] LVL_FULL = (PTRW+1)'(DEPTH);

    logic [MDATAW-1:0] stack [DEPTH];
    logic [MDATAW-1:0] base_q;
    logic [PTRW:0]     level_q;
    logic              ovf_q;
    logic              unf_q;

    logic [MDATAW-1:0] nb;
    logic [PTRW:0]     level_m1;
    logic              full_w;
    logic              empty_w;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;

    always_comb begin
        nb       = bus.rel ? base_q + bus.new_base : bus.new_base;
        level_m1 = level_q - LVL_ONE;
        full_w   = (level_q == LVL_FULL);
        empty_w  = (level_q == '0);
        do_push  = bus.call && !bus.ret && !full_w;
        do_pop   = bus.ret && !bus.call && !empty_w;
        set_ovf  = bus.call && !bus.ret && full_w;
        set_unf  = bus.ret && !bus.call && empty_w;
    end

    // Saved-base storage carries no reset; only the level decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            stack[level_q[PTRW-1:0]] <= base_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.call && bus.ret) begin
                base_q <= nb;
            end else if (do_push) begin
                base_q  <= nb;
                level_q <= level_q + LVL_ONE;
            end else if (do_pop) begin
                base_q  <= stack[level_m1[PTRW-1:0]];
                level_q <= level_m1;
            end
            // A set in the same cycle as clr_err wins.
            ovf_q <= set_ovf || (ovf_q && !bus.clr_err);
            unf_q <= set_unf || (unf_q && !bus.clr_err);
        end
    end

    assign bus.base    = base_q;
    assign bus.level   = level_q;
    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
    assign bus.err_ovf = ovf_q;
    assign bus.err_unf = unf_q;
endmodule

// File: tb/tb_frame_base_stack.sv
// Self-checking bench for frame_base_stack: directed scenarios plus random traffic
// against a queue-based model of the saved-base stack.
module tb_frame_base_stack;
    localparam int MDATAW = 8;
    localparam int DEPTH  = 8;
    localparam int PTRW   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int   m_base = 0;
    int   m_q[$];
    bit   m_ovf = 0;
    bit   m_unf = 0;

    frame_base_stack_if #(.MDATAW(MDATAW), .PTRW(PTRW)) bus ();

    frame_base_stack #(.MDATAW(MDATAW), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rstn, input bit c, input bit r, input bit rl,
                              input int nbin, input bit clr);
        int  nbv;
        bit  so;
        bit  su;
        so = 0;
        su = 0;
        if (!rstn) begin
            m_q.delete();
            m_base = 0;
            m_ovf  = 0;
            m_unf  = 0;
        end else begin
            nbv = rl ? (m_base + nbin) % 256 : nbin;
            if (c && r) begin
                m_base = nbv;
            end else if (c) begin
                if (m_q.size() == DEPTH) so = 1;
                else begin
                    m_q.push_back(m_base);
                    m_base = nbv;
                end
            end else if (r) begin
                if (m_q.size() == 0) su = 1;
                else m_base = m_q.pop_back();
            end
            if (clr) begin
                m_ovf = 0;
                m_unf = 0;
            end
            m_ovf = m_ovf | so;
            m_unf = m_unf | su;
        end
    endtask

    // Drive one request cycle, advance the model, then compare every output.
    task automatic cyc(input bit rstn, input bit c, input bit r, input bit rl,
                       input int nbin, input bit clr);
        rst_n        = rstn;
        bus.call     = c;
        bus.ret      = r;
        bus.rel      = rl;
        bus.new_base = nbin[MDATAW-1:0];
        bus.clr_err  = clr;
        @(posedge clk);
        #1;
        model_step(rstn, c, r, rl, nbin, clr);
        check("base",    32'(bus.base),    32'(m_base));
        check("level",   32'(bus.level),   32'(m_q.size()));
        check("full",    32'(bus.full),    32'(m_q.size() == DEPTH));
        check("empty",   32'(bus.empty),   32'(m_q.size() == 0));
        check("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
        check("err_unf", 32'(bus.err_unf), 32'(m_unf));
        bus.call    = 1'b0;
        bus.ret     = 1'b0;
        bus.clr_err = 1'b0;
        rst_n       = 1'b1;
    endtask

    initial begin
        bus.call = 0; bus.ret = 0; bus.rel = 0; bus.new_base = '0; bus.clr_err = 0;
        #2;

        // reset
        cyc(0, 0, 0, 0, 0, 0);
        check("rst_base", 32'(bus.base), 32'h0);
        check("rst_empty", 32'(bus.empty), 32'h1);

        // nested absolute calls and returns
        cyc(1, 1, 0, 0, 'h10, 0); check("t2_b1", 32'(bus.base), 32'h10);
        cyc(1, 1, 0, 0, 'h40, 0); check("t2_b2", 32'(bus.base), 32'h40);
        check("t2_lvl2", 32'(bus.level), 32'h2);
        cyc(1, 0, 1, 0, 0, 0);    check("t2_b3", 32'(bus.base), 32'h10);
        cyc(1, 0, 1, 0, 0, 0);    check("t2_b4", 32'(bus.base), 32'h00);
        check("t2_empty", 32'(bus.empty), 32'h1);

        // relative call wraps modulo 2^MDATAW
        cyc(1, 1, 1, 0, 'hF0, 0); check("t3_b0", 32'(bus.base), 32'hF0);
        cyc(1, 1, 0, 1, 'h20, 0); check("t3_wrap", 32'(bus.base), 32'h10);
        check("t3_lvl", 32'(bus.level), 32'h1);
        cyc(1, 0, 1, 0, 0, 0);    check("t3_ret", 32'(bus.base), 32'hF0);

        // fill to DEPTH, overflow, drain
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) cyc(1, 1, 0, 0, i, 0);
        check("t4_full", 32'(bus.full), 32'h1);
        cyc(1, 1, 0, 0, 'h99, 0);
        check("t4_ovf_base", 32'(bus.base), 32'h8);
        check("t4_ovf_lvl", 32'(bus.level), 32'h8);
        check("t4_ovf", 32'(bus.err_ovf), 32'h1);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, 0, 0, 0);
        check("t4_drain_base", 32'(bus.base), 32'h0);
        check("t4_drain_empty", 32'(bus.empty), 32'h1);

        // underflow, set-wins-over-clear, then clear
        cyc(1, 0, 1, 0, 0, 0);
        check("t5_unf", 32'(bus.err_unf), 32'h1);
        cyc(1, 0, 1, 0, 0, 1);
        check("t5_setwins", 32'(bus.err_unf), 32'h1);
        cyc(1, 0, 0, 0, 0, 1);
        check("t5_clr", 32'(bus.err_unf), 32'h0);
        check("t5_clr_ovf", 32'(bus.err_ovf), 32'h0);

        // tail call, return, reset mid-sequence
        cyc(1, 1, 0, 0, 'h10, 0);
        cyc(1, 1, 0, 0, 'h30, 0);
        cyc(1, 1, 1, 0, 'h55, 0);
        check("t6_tail_base", 32'(bus.base), 32'h55);
        check("t6_tail_lvl", 32'(bus.level), 32'h2);
        cyc(1, 0, 1, 0, 0, 0);
        check("t6_ret", 32'(bus.base), 32'h10);
        cyc(1, 1, 0, 0, 'h20, 0);
        cyc(0, 1, 0, 0, 'h77, 1);
        check("t6_rst_base", 32'(bus.base), 32'h0);
        check("t6_rst_lvl", 32'(bus.level), 32'h0);

        // random traffic, biased so the stack reaches both ends
        for (int i = 0; i < 600; i++) begin
            int sel;
            bit c;
            bit r;
            sel = int'($urandom_range(0, 99));
            c = (sel < 45) || (sel >= 90 && sel < 95);
            r = (sel >= 45 && sel < 90) || (sel >= 90 && sel < 95);
            cyc(($urandom_range(0, 99) != 0), c, r, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
